alien_hit_tracker: RTL and testbench

- Downstream consumer of the alien motion block's outputs (AlienX, AlienY, AlienSX, AlienSY).
- Treats the motion block's position as the centre of alien (row 0, col 0) in a ROWS x COLS formation.
- Once per frame, scans every live alien against the player missile and kills at most one alien per frame.
- Maintains the alive mask, score and wave-clear flag for the colour mapper, the missile block and the game FSM.

---
 rtl/alien_pkg.sv | 21 ++
 rtl/alien_hit_cmp.sv | 22 ++
 rtl/alien_hit_tracker.sv | 178 +++++++++++++++++
 tb/tb_alien_hit_tracker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alien_pkg.sv
// Shared types and constants for the alien formation hit tracker.
package alien_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam int unsigned ROWS_DEF    = 4;
    localparam int unsigned COLS_DEF    = 8;
    localparam int unsigned NUM_ALIENS  = ROWS_DEF * COLS_DEF;
    localparam int unsigned IDX_W       = $clog2(NUM_ALIENS);

    localparam int unsigned PTS_ROW0    = 30;
    localparam int unsigned PTS_ROW12   = 20;
    localparam int unsigned PTS_DEFAULT = 10;

    function automatic logic [15:0] row_points(input int unsigned row);
        if (row == 0)      return 16'(PTS_ROW0);
        else if (row <= 2) return 16'(PTS_ROW12);
        else               return 16'(PTS_DEFAULT);
    endfunction

endpackage

// File: rtl/alien_hit_cmp.sv
// Point-in-box test: missile point against a centre with inclusive half-extents.
module alien_hit_cmp (
    input  logic signed [11:0] cx_i,
    input  logic signed [11:0] cy_i,
    input  logic        [9:0]  sx_i,
    input  logic        [9:0]  sy_i,
    input  logic        [9:0]  mx_i,
    input  logic        [9:0]  my_i,
    output logic               overlap_o
);

    logic signed [11:0] dx, dy, adx, ady;

    always_comb begin
        dx  = $signed({2'b00, mx_i}) - cx_i;
        dy  = $signed({2'b00, my_i}) - cy_i;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        overlap_o = (adx <= $signed({2'b00, sx_i})) && (ady <= $signed({2'b00, sy_i}));
    end

endmodule

// File: rtl/alien_hit_tracker.sv
// Per-frame missile-vs-formation scan; one alien per cycle, at most one kill per frame.
// Optional ROW_POINTS_EN: kill score depends on the row of the alien.
module alien_hit_tracker
    import alien_pkg::*;
#(
    parameter int unsigned ROWS      = ROWS_DEF,
    parameter int unsigned COLS      = COLS_DEF,
    parameter int unsigned SPACING_X = 60,
    parameter int unsigned SPACING_Y = 45,
    parameter int unsigned POINTS    = PTS_DEFAULT
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            frame_start,
    input  logic                            new_wave,
    input  logic [9:0]                      AlienX,
    input  logic [9:0]                      AlienY,
    input  logic [9:0]                      AlienSX,
    input  logic [9:0]                      AlienSY,
    input  logic [9:0]                      MissileX,
    input  logic [9:0]                      MissileY,
    input  logic                            missile_active,
    output logic [ROWS*COLS-1:0]            alive_mask,
    output logic                            hit,
    output logic [$clog2(ROWS*COLS)-1:0]    hit_index,
    output logic [15:0]                     score,
    output logic                            wave_clear,
    output logic                            busy,
    output logic                            scan_done
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [9:0]      ax_q, ay_q, sx_q, sy_q, mx_q, my_q;
    logic            ma_q;
    logic            snap_en;
    logic [N-1:0]    alive_q, alive_d;
    logic            hit_q, hit_d;
    logic [IW-1:0]   hit_index_q, hit_index_d;
    logic [15:0]     score_q, score_d;
    logic            wave_clear_q, wave_clear_d;

    logic signed [11:0] cx, cy;
    logic               overlap;
    logic [15:0]        pts;
    logic [16:0]        score_sum;

    always_comb begin
        cx = $signed({2'b00, ax_q}) + $signed(12'(32'(col_q) * SPACING_X));
        cy = $signed({2'b00, ay_q}) + $signed(12'(32'(row_q) * SPACING_Y));
`ifdef ROW_POINTS_EN
        pts = row_points(32'(row_q));
`else
        pts = 16'(POINTS);
`endif
        score_sum = {1'b0, score_q} + {1'b0, pts};
    end

    alien_hit_cmp u_cmp (
        .cx_i      (cx),
        .cy_i      (cy),
        .sx_i      (sx_q),
        .sy_i      (sy_q),
        .mx_i      (mx_q),
        .my_i      (my_q),
        .overlap_o (overlap)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        row_d        = row_q;
        col_d        = col_q;
        snap_en      = 1'b0;
        alive_d      = alive_q;
        hit_d        = 1'b0;
        hit_index_d  = hit_index_q;
        score_d      = score_q;
        wave_clear_d = wave_clear_q;

        if (new_wave) begin
            alive_d      = '1;
            wave_clear_d = 1'b0;
            state_d      = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        snap_en = 1'b1;
                        idx_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (alive_q[idx_q] && ma_q && overlap) begin
                        alive_d[idx_q] = 1'b0;
                        hit_d          = 1'b1;
                        hit_index_d    = idx_q;
                        score_d        = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                        state_d        = DONE;
                    end else if (idx_q == IW'(N - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (col_q == CW'(COLS - 1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                    // Flag is visible in the same cycle as scan_done.
                    if (state_d == DONE) wave_clear_d = ~|alive_d;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            ax_q         <= '0;
            ay_q         <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            mx_q         <= '0;
            my_q         <= '0;
            ma_q         <= 1'b0;
            alive_q      <= '1;
            hit_q        <= 1'b0;
            hit_index_q  <= '0;
            score_q      <= '0;
            wave_clear_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            row_q        <= row_d;
            col_q        <= col_d;
            alive_q      <= alive_d;
            hit_q        <= hit_d;
            hit_index_q  <= hit_index_d;
            score_q      <= score_d;
            wave_clear_q <= wave_clear_d;
            if (snap_en) begin
                ax_q <= AlienX;
                ay_q <= AlienY;
                sx_q <= AlienSX;
                sy_q <= AlienSY;
                mx_q <= MissileX;
                my_q <= MissileY;
                ma_q <= missile_active;
            end
        end
    end

    assign alive_mask = alive_q;
    assign hit        = hit_q;
    assign hit_index  = hit_index_q;
    assign score      = score_q;
    assign wave_clear = wave_clear_q;
    assign busy       = (state_q != IDLE);
    assign scan_done  = (state_q == DONE);

endmodule

// File: tb/tb_alien_hit_tracker.sv
// Directed bench for alien_hit_tracker; honours ROW_POINTS_EN in its score model.
module tb_alien_hit_tracker;

    logic        Clk = 1'b0;
    logic        Reset, frame_start, new_wave, missile_active;
    logic [9:0]  AlienX, AlienY, AlienSX, AlienSY, MissileX, MissileY;
    logic [31:0] alive_mask;
    logic        hit, wave_clear, busy, scan_done;
    logic [4:0]  hit_index;
    logic [15:0] score;

    int total = 0;
    int bad   = 0;

    alien_hit_tracker dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_start    (frame_start),
        .new_wave       (new_wave),
        .AlienX         (AlienX),
        .AlienY         (AlienY),
        .AlienSX        (AlienSX),
        .AlienSY        (AlienSY),
        .MissileX       (MissileX),
        .MissileY       (MissileY),
        .missile_active (missile_active),
        .alive_mask     (alive_mask),
        .hit            (hit),
        .hit_index      (hit_index),
        .score          (score),
        .wave_clear     (wave_clear),
        .busy           (busy),
        .scan_done      (scan_done)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pts(input int idx);
`ifdef ROW_POINTS_EN
        int row = idx / 8;
        if (row == 0) return 30;
        else if (row <= 2) return 20;
        else return 10;
`else
        return 10;
`endif
    endfunction

    function automatic int sat_add(input int s, input int p);
        return (s + p > 65535) ? 65535 : s + p;
    endfunction

    // Pulses frame_start in cycle 0 and watches cycles 1..40; ends in the scan_done cycle.
    task automatic run_scan(input int extra_fs, output int hc, output int hi, output int dc,
                            output logic b1, output logic wc);
        hc = -1; hi = -1; dc = -1; b1 = 1'b0; wc = 1'b0;
        frame_start = 1'b1;
        step();
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) b1 = busy;
            if (hit && hc < 0) begin hc = c; hi = int'(hit_index); end
            if (scan_done && dc < 0) begin dc = c; wc = wave_clear; end
            if (dc >= 0) break;
            frame_start = (c == extra_fs);
            step();
        end
        frame_start = 1'b0;
    endtask

    task automatic pulse_new_wave();
        new_wave = 1'b1;
        step();
        new_wave = 1'b0;
    endtask

    task automatic kill_fast();
        pulse_new_wave();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        int   hc, hi, dc, sc, iter;
        logic b1, wc, seen;

        Reset = 1'b1; frame_start = 1'b0; new_wave = 1'b0; missile_active = 1'b0;
        AlienX = '0; AlienY = '0; AlienSX = '0; AlienSY = '0; MissileX = '0; MissileY = '0;
        step(); step();
        Reset = 1'b0;
        step();
        check("rst_mask", alive_mask, 32'hFFFF_FFFF);
        check("rst_score", 32'(score), 0);
        check("rst_hit", 32'(hit), 0);
        check("rst_hit_index", 32'(hit_index), 0);
        check("rst_wave_clear", 32'(wave_clear), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_scan_done", 32'(scan_done), 0);
        sc = 0;

        // Test 1: missile on alien 9 centre.
        AlienX = 100; AlienY = 60; AlienSX = 25; AlienSY = 20;
        MissileX = 160; MissileY = 105; missile_active = 1'b1;
        run_scan(-1, hc, hi, dc, b1, wc);
        check("t1_hit_cycle", 32'(hc), 11);
        check("t1_hit_index", 32'(hi), 9);
        check("t1_done_cycle", 32'(dc), 11);
        check("t1_busy_c1", 32'(b1), 1);
        step();
        sc = sat_add(sc, pts(9));
        check("t1_mask", alive_mask, 32'hFFFF_FDFF);
        check("t1_score", 32'(score), 32'(sc));
        check("t1_busy_after", 32'(busy), 0);

        // Test 2: inclusive bound then one pixel outside.
        pulse_new_wave();
        MissileX = 185;
        run_scan(-1, hc, hi, dc, b1, wc);
        check("t2_edge_hit_cycle", 32'(hc), 11);
        check("t2_edge_hit_index", 32'(hi), 9);
        step();
        sc = sat_add(sc, pts(9));
        MissileX = 186;
        run_scan(-1, hc, hi, dc, b1, wc);
        check("t2_out_hit", 32'(hc), 32'(-1));
        check("t2_out_done_cycle", 32'(dc), 33);
        step();
        check("t2_score", 32'(score), 32'(sc));

        // Test 3: inactive missile; re-trigger while busy is dropped.
        pulse_new_wave();
        MissileX = 100; MissileY = 60; missile_active = 1'b0;
        run_scan(5, hc, hi, dc, b1, wc);
        check("t3_hit", 32'(hc), 32'(-1));
        check("t3_done_cycle", 32'(dc), 33);
        step(); step(); step();
        check("t3_busy_idle", 32'(busy), 0);
        check("t3_mask", alive_mask, 32'hFFFF_FFFF);

        // Test 5: every alien overlaps; lowest alive dies each frame.
        AlienSX = 1000; AlienSY = 1000; MissileX = 160; MissileY = 105; missile_active = 1'b1;
        for (int k = 0; k < 32; k++) begin
            run_scan(-1, hc, hi, dc, b1, wc);
            check($sformatf("t5_idx%0d", k), 32'(hi), 32'(k));
            if (k == 30) check("t5_wc_early", 32'(wc), 0);
            if (k == 31) check("t5_wc_final", 32'(wc), 1);
            sc = sat_add(sc, pts(k));
            step();
        end
        check("t5_mask_empty", alive_mask, 32'h0);
        check("t5_score", 32'(score), 32'(sc));
        pulse_new_wave();
        check("t5_nw_mask", alive_mask, 32'hFFFF_FFFF);
        check("t5_nw_wc", 32'(wave_clear), 0);
        check("t5_nw_score", 32'(score), 32'(sc));

        // Test 6: new_wave in cycle 4 aborts a scan bound for alien 9.
        AlienSX = 25; AlienSY = 20; MissileX = 100; MissileY = 60;
        run_scan(-1, hc, hi, dc, b1, wc);
        check("t6_pre_kill", 32'(hi), 0);
        step();
        sc = sat_add(sc, pts(0));
        check("t6_pre_mask", alive_mask, 32'hFFFF_FFFE);
        MissileX = 160; MissileY = 105;
        seen = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int c = 1; c < 4; c++) begin
            seen = seen | hit | scan_done;
            step();
        end
        seen = seen | hit | scan_done;
        new_wave = 1'b1;
        step();
        new_wave = 1'b0;
        check("t6_busy_low", 32'(busy), 0);
        check("t6_mask", alive_mask, 32'hFFFF_FFFF);
        for (int c = 5; c <= 15; c++) begin
            seen = seen | hit | scan_done;
            step();
        end
        check("t6_no_hit_or_done", 32'(seen), 0);
        check("t6_score", 32'(score), 32'(sc));

        // Test 4: drive score up to saturation with fast alien-0 kills.
        AlienSX = 1000; AlienSY = 1000;
        iter = 0;
        while (sc + pts(0) <= 65535 && iter < 7000) begin
            kill_fast();
            sc = sc + pts(0);
            iter++;
        end
        check("t4_pre_sat", 32'(score), 32'(sc));
        kill_fast();
        check("t4_sat", 32'(score), 32'hFFFF);
        kill_fast();
        check("t4_sat_hold", 32'(score), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
